// File: rtl/serial_cmd_pkg.sv
// Shared constants and state encodings for the serial command initiator
// and the command processor it talks to.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_SOF   = 8'hA5;
  localparam logic [7:0] RSP_SOF   = 8'h5A;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] STATUS_OK = 8'h00;

  localparam logic [1:0] RSP_ERR_OK      = 2'd0;
  localparam logic [1:0] RSP_ERR_CHK     = 2'd1;
  localparam logic [1:0] RSP_ERR_TIMEOUT = 2'd2;

  localparam int CMD_FRAME_LEN = 5;
  localparam int RSP_FRAME_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOAD,
    ST_TX_WAIT,
    ST_RX_WAIT,
    ST_RX_BYTE,
    ST_DONE
  } initiator_state_t;

endpackage

// File: rtl/serial_frame_xor.sv
// Running XOR accumulator used to build and verify frame checksums.
module serial_frame_xor (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (enable) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/serial_cmd_initiator.sv
// Host-side master: serialises a register request into a 5-byte command frame
// over a quick_rs232 byte interface and checks the 4-byte response frame.
module serial_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter logic [7:0]  CMD_SOF        = serial_cmd_pkg::CMD_SOF,
  parameter logic [7:0]  RSP_SOF        = serial_cmd_pkg::RSP_SOF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_status,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  input  logic       tx_data_copied,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_byte_received,
  output logic       rx_read
);
  import serial_cmd_pkg::*;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  initiator_state_t state, state_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [1:0]  rx_idx, rx_idx_n;
  logic        req_write_q, req_write_n;
  logic [7:0]  req_addr_q, req_addr_n;
  logic [7:0]  req_wdata_q, req_wdata_n;
  logic [7:0]  rx_byte_q, rx_byte_n;
  logic [7:0]  rx_status_q, rx_status_n;
  logic [7:0]  rx_rdata_q, rx_rdata_n;
  logic [31:0] tmo_cnt, tmo_cnt_n;
  logic        rx_prev;
  logic [7:0]  tx_data_n;
  logic        tx_data_ready_n, rx_read_n, rsp_valid_n;
  logic [7:0]  rsp_status_n, rsp_rdata_n;
  logic [1:0]  rsp_err_n;
  logic        xor_clear, xor_en;
  logic [7:0]  xor_data, xor_acc;
  logic [7:0]  frame_byte;
  logic        rx_rise;

  serial_frame_xor u_xor (
    .clk    (clk),
    .rst    (rst),
    .clear  (xor_clear),
    .enable (xor_en),
    .data   (xor_data),
    .acc    (xor_acc)
  );

  assign rx_rise   = rx_byte_received & ~rx_prev;
  assign req_ready = (state == ST_IDLE);

  // The checksum slot sends the accumulator, which by then holds bytes 0..3.
  always_comb begin
    case (byte_idx)
      3'd0:    frame_byte = CMD_SOF;
      3'd1:    frame_byte = req_write_q ? CMD_WRITE : CMD_READ;
      3'd2:    frame_byte = req_addr_q;
      3'd3:    frame_byte = req_wdata_q;
      default: frame_byte = xor_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      byte_idx      <= 3'd0;
      rx_idx        <= 2'd0;
      req_write_q   <= 1'b0;
      req_addr_q    <= 8'h00;
      req_wdata_q   <= 8'h00;
      rx_byte_q     <= 8'h00;
      rx_status_q   <= 8'h00;
      rx_rdata_q    <= 8'h00;
      tmo_cnt       <= 32'd0;
      rx_prev       <= 1'b0;
      tx_data       <= 8'h00;
      tx_data_ready <= 1'b0;
      rx_read       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= 8'h00;
      rsp_rdata     <= 8'h00;
      rsp_err       <= RSP_ERR_OK;
    end else begin
      state         <= state_n;
      byte_idx      <= byte_idx_n;
      rx_idx        <= rx_idx_n;
      req_write_q   <= req_write_n;
      req_addr_q    <= req_addr_n;
      req_wdata_q   <= req_wdata_n;
      rx_byte_q     <= rx_byte_n;
      rx_status_q   <= rx_status_n;
      rx_rdata_q    <= rx_rdata_n;
      tmo_cnt       <= tmo_cnt_n;
      rx_prev       <= rx_byte_received;
      tx_data       <= tx_data_n;
      tx_data_ready <= tx_data_ready_n;
      rx_read       <= rx_read_n;
      rsp_valid     <= rsp_valid_n;
      rsp_status    <= rsp_status_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_err       <= rsp_err_n;
    end
  end

  always_comb begin
    state_n         = state;
    byte_idx_n      = byte_idx;
    rx_idx_n        = rx_idx;
    req_write_n     = req_write_q;
    req_addr_n      = req_addr_q;
    req_wdata_n     = req_wdata_q;
    rx_byte_n       = rx_byte_q;
    rx_status_n     = rx_status_q;
    rx_rdata_n      = rx_rdata_q;
    tmo_cnt_n       = tmo_cnt;
    tx_data_n       = tx_data;
    tx_data_ready_n = tx_data_ready;
    rx_read_n       = 1'b0;
    rsp_valid_n     = 1'b0;
    rsp_status_n    = rsp_status;
    rsp_rdata_n     = rsp_rdata;
    rsp_err_n       = rsp_err;
    xor_clear       = 1'b0;
    xor_en          = 1'b0;
    xor_data        = frame_byte;

    case (state)
      ST_IDLE: begin
        if (rx_rise) rx_read_n = 1'b1;
        if (req_valid) begin
          req_write_n = req_write;
          req_addr_n  = req_addr;
          req_wdata_n = req_write ? req_wdata : 8'h00;
          byte_idx_n  = 3'd0;
          rx_idx_n    = 2'd0;
          rx_status_n = 8'h00;
          rx_rdata_n  = 8'h00;
          xor_clear   = 1'b1;
          state_n     = ST_TX_LOAD;
        end
      end

      ST_TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_n       = frame_byte;
          tx_data_ready_n = 1'b1;
          xor_en          = (byte_idx != 3'd4);
          state_n         = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (tx_data_copied) begin
          tx_data_ready_n = 1'b0;
          if (byte_idx == 3'd4) begin
            tmo_cnt_n = 32'd0;
            xor_clear = 1'b1;
            state_n   = ST_RX_WAIT;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = ST_TX_LOAD;
          end
        end
      end

      // Timeout is checked first so it wins over a byte arriving the same cycle.
      ST_RX_WAIT: begin
        if (tmo_cnt == TIMEOUT_LAST) begin
          rsp_err_n    = RSP_ERR_TIMEOUT;
          rsp_status_n = rx_status_q;
          rsp_rdata_n  = rx_rdata_q;
          rsp_valid_n  = 1'b1;
          state_n      = ST_DONE;
        end else begin
          if (tmo_cnt != 32'hFFFF_FFFF) tmo_cnt_n = tmo_cnt + 32'd1;
          if (rx_rise) begin
            rx_byte_n = rx_data;
            rx_read_n = 1'b1;
            state_n   = ST_RX_BYTE;
          end
        end
      end

      ST_RX_BYTE: begin
        xor_data = rx_byte_q;
        state_n  = ST_RX_WAIT;
        case (rx_idx)
          2'd0: begin
            if (rx_byte_q == RSP_SOF) begin
              xor_en   = 1'b1;
              rx_idx_n = 2'd1;
            end
          end
          2'd1: begin
            rx_status_n = rx_byte_q;
            xor_en      = 1'b1;
            rx_idx_n    = 2'd2;
          end
          2'd2: begin
            rx_rdata_n = rx_byte_q;
            xor_en     = 1'b1;
            rx_idx_n   = 2'd3;
          end
          default: begin
            rsp_err_n    = (rx_byte_q == xor_acc) ? RSP_ERR_OK : RSP_ERR_CHK;
            rsp_status_n = rx_status_q;
            rsp_rdata_n  = rx_rdata_q;
            rsp_valid_n  = 1'b1;
            state_n      = ST_DONE;
          end
        endcase
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Directed self-checking bench for serial_cmd_initiator: models the
// quick_rs232 byte interface and checks frames, responses and timing.
module tb_serial_cmd_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_byte_received = 1'b0;
  logic       rx_read;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_copy_cyc = 0;
  int rsp_count = 0;
  int rsp_cyc = 0;
  int pop_count = 0;
  logic [7:0] cap_status, cap_rdata;
  logic [1:0] cap_err;

  serial_cmd_initiator #(.TIMEOUT_CYCLES(1000)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_status       (rsp_status),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .tx_data          (tx_data),
    .tx_data_ready    (tx_data_ready),
    .tx_data_copied   (tx_data_copied),
    .tx_busy          (tx_busy),
    .rx_data          (rx_data),
    .rx_byte_received (rx_byte_received),
    .rx_read          (rx_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count  = rsp_count + 1;
      rsp_cyc    = cyc;
      cap_status = rsp_status;
      cap_rdata  = rsp_rdata;
      cap_err    = rsp_err;
    end
    if (rx_read) pop_count = pop_count + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic issueRequest(input bit wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input string tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({tag, "_req_ready_low"}, req_ready, 0);
    checkOutput({tag, "_lat_n1"}, tx_data_ready, 0);
    @(negedge clk);
    checkOutput({tag, "_lat_n2"}, tx_data_ready, 1);
  endtask

  task automatic collectTx(input logic [39:0] exp_tx, input int n,
                           input bit toggle, input string tag);
    logic [39:0] e;
    int wait_cnt;
    bit seen;
    e = exp_tx;
    for (int i = 0; i < n; i++) begin
      wait_cnt = 0;
      seen = tx_data_ready;
      while (!seen && wait_cnt < 100) begin
        @(negedge clk);
        seen = tx_data_ready;
        if (toggle && !seen) tx_busy = ~tx_busy;
        wait_cnt++;
      end
      checkOutput($sformatf("%s_tx%0d_seen", tag, i), seen, 1);
      if (!seen) return;
      checkOutput($sformatf("%s_tx%0d", tag, i), tx_data, e[39-8*i -: 8]);
      tx_data_copied = 1'b1;
      @(negedge clk);
      tx_data_copied = 1'b0;
      last_copy_cyc = cyc;
      checkOutput($sformatf("%s_tx%0d_drop", tag, i), tx_data_ready, 0);
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input string tag);
    bit popped;
    popped = 1'b0;
    @(negedge clk);
    rx_data = b;
    rx_byte_received = 1'b1;
    for (int k = 0; k < 20 && !popped; k++) begin
      @(negedge clk);
      popped = rx_read;
    end
    checkOutput({tag, "_rx_pop"}, popped, 1);
    rx_byte_received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [39:0] exp_tx, input logic [47:0] rx, input int n_rx,
                               input logic [7:0] exp_status, input logic [7:0] exp_rdata,
                               input logic [1:0] exp_err, input string tag);
    int start_rsp, start_pop, waited;
    logic [47:0] r;
    r = rx;
    start_rsp = rsp_count;
    issueRequest(wr, addr, wdata, tag);
    collectTx(exp_tx, 5, 1'b0, tag);
    start_pop = pop_count;
    for (int i = 0; i < n_rx; i++) sendRx(r[8*(n_rx-1-i) +: 8], tag);
    waited = 0;
    while (rsp_count == start_rsp && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, "_rsp_pulses"}, rsp_count - start_rsp, 1);
    checkOutput({tag, "_pops"}, pop_count - start_pop, n_rx);
    checkOutput({tag, "_status"}, cap_status, exp_status);
    checkOutput({tag, "_rdata"}, cap_rdata, exp_rdata);
    checkOutput({tag, "_err"}, cap_err, exp_err);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    if (n_rx == 0) checkOutput({tag, "_tmo_cycles"}, rsp_cyc - last_copy_cyc, 1000);
  endtask

  initial begin
    int start_rsp;
    bit seen;
    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_tx_ready", tx_data_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rx_read", rx_read, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 8'h10, 8'h3C, 40'hA502103C8B, 48'h00005A003C66, 4,
                  8'h00, 8'h3C, 2'd0, "write");
    applyStimulus(1'b0, 8'h05, 8'h99, 40'hA5010500A1, 48'h00005A00772D, 4,
                  8'h00, 8'h77, 2'd0, "read");
    applyStimulus(1'b0, 8'h05, 8'h00, 40'hA5010500A1, 48'h00005A007700, 4,
                  8'h00, 8'h77, 2'd1, "chk_err");
    applyStimulus(1'b0, 8'h05, 8'h00, 40'hA5010500A1, 48'h0, 0,
                  8'h00, 8'h00, 2'd2, "timeout");
    applyStimulus(1'b0, 8'h05, 8'h00, 40'hA5010500A1, 48'h13FF5A01005B, 6,
                  8'h01, 8'h00, 2'd0, "garbage");

    issueRequest(1'b1, 8'h20, 8'h11, "rst");
    collectTx(40'hA502201196, 3, 1'b1, "rst");
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = tx_data_ready;
      if (!seen) tx_busy = ~tx_busy;
    end
    checkOutput("rst_tx3_seen", seen, 1);
    checkOutput("rst_tx3", tx_data, 8'h11);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_tx_ready", tx_data_ready, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_status", rsp_status, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_rx_read", rx_read, 0);
    tx_busy = 1'b0;
    start_rsp = rsp_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_stale_rsp", rsp_count - start_rsp, 0);
    applyStimulus(1'b1, 8'h10, 8'h3C, 40'hA502103C8B, 48'h00005A003C66, 4,
                  8'h00, 8'h3C, 2'd0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
